rr_lock_arbiter: RTL
====================

Name: rr_lock_arbiter

Overview:
- Shares one resource among N_REQ requesters using round-robin priority.
- Unlike a fixed-priority grant, a winner holds its grant across many cycles until it signals done, drops its request, or a hold watchdog expires.
- Sits between the requester blocks and the shared resource. The registered one-hot grant and encoded owner id drive the resource's select mux.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced release; legal range 2..255.
- ID_W, $clog2(N_REQ), width of gnt_id (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  N_REQ  per-requester request level; requester holds it high while it wants or owns the resource.
- done  input  N_REQ  per-requester release pulse; only the owner's bit is honoured.
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- gnt_id  output  ID_W  index of current owner; holds last owner when idle.
- busy  output  1  high while any grant is active (equals OR of gnt).
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async, immediate, also mid-grant):
  - gnt=0, gnt_id=0, busy=0, timeout=0.
  - state=IDLE, hold counter=0.
  - Priority pointer=0, so req[0] has highest priority first.
- States: IDLE, GRANT.
- IDLE:
  - Each cycle, rr_pick searches req starting at pointer, ascending, wrapping from N_REQ-1 to 0.
  - If any req is high at edge k, then from cycle k+1: gnt[i]=1, gnt_id=i, busy=1, state=GRANT, counter=0.
  - Pointer becomes (i+1) mod N_REQ.
  - If no req, remain IDLE with outputs low.
- GRANT, owner i; counter increments each GRANT cycle. Release conditions, in priority order:
  - (a) done[i]=1 or req[i]=0 at edge m: gnt=0 and busy=0 from cycle m+1; state=IDLE; timeout=0.
  - (b) Watchdog (macro enabled only): counter==MAX_HOLD-1 with no release at edge m. gnt drops at m+1 and timeout=1 for exactly cycle m+1. Owner therefore held exactly MAX_HOLD cycles.
- Grant latency: 1 cycle from request to grant.
- Mandatory one dead cycle after every release. The next grant is visible at the earliest at m+2, giving the resource a clean turnaround.
- done bits of non-owners are ignored. done in IDLE is ignored.
- done and watchdog expiry in the same cycle count as a normal release; timeout stays 0.
- Owner re-requesting continuously: after release it competes normally; pointer already moved past it, so other pending requesters win first.
- Lone requester: re-granted every other cycle pattern (grant, dead, grant...).
- A req change on a non-owner during GRANT has no effect until IDLE.
- gnt is never multi-hot. gnt_id is updated only on a new grant.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined: watchdog counter present; release rule (b) active; timeout pulses as above.
- Undefined: counter logic removed; grant held indefinitely until done/req drop; timeout tied to 0.
- MAX_HOLD unused when the macro is undefined.

Decomposition:
- Package arb_pkg:
  - state enum (ARB_IDLE, ARB_GRANT).
  - Default N_REQ/MAX_HOLD constants.
  - Helper function for wrap-around pointer increment.
- Sub-module rr_pick, combinational:
  - Inputs: req, pointer.
  - Outputs: one-hot pick, pick_id, pick_valid.
  - Implemented as double-width masked priority search.
- Top holds FSM, pointer, counter, and output registers.

Test Plan:
- Reset mid-grant: assert rst while gnt=4'b0010 -> gnt=0, busy=0 immediately; first post-reset grant with req=4'b1111 goes to req[0].
- Round-robin fairness: req=4'b1111 held, each owner pulses done 3 cycles after grant -> grant order 0,1,2,3,0; one dead cycle between grants; gnt_id follows 0,1,2,3,0.
- Release by request drop: owner 2 drops req without done at edge m -> gnt=0 at m+1; next grant (req=4'b0001) at m+2 to requester 0.
- Watchdog (macro on, MAX_HOLD=16): req=4'b0100 held, no done -> gnt[2] high exactly 16 cycles, timeout high 1 cycle coincident with gnt drop; done at counter==15 instead -> timeout stays 0.
- Macro off: same stimulus, no done for 100 cycles -> gnt[2] stays high throughout, timeout never asserts.
- Non-owner done and wrap: owner 3, done=4'b0001 pulse -> ignored, grant retained; after owner 3 releases with req=4'b1001 pending -> next grant to requester 0 (pointer wrapped).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    localparam int ARB_N_REQ_DEF    = 4;
    localparam int ARB_MAX_HOLD_DEF = 16;

    // Next round-robin start position: one past the winner, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N_REQ = ARB_N_REQ_DEF,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_valid
);

    logic [N_REQ-1:0]   mask;
    logic [2*N_REQ-1:0] dbl;
    int                 hit;
    int                 idx;

    // Low half holds requests at or above the pointer, high half the full
    // vector, so the lowest set bit overall is the round-robin winner.
    always_comb begin
        mask       = '0;
        dbl        = '0;
        hit        = -1;
        idx        = 0;
        pick       = '0;
        pick_id    = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};
        for (int j = 2 * N_REQ - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                hit = j;
            end
        end
        if (hit >= 0) begin
            idx        = (hit >= N_REQ) ? hit - N_REQ : hit;
            pick_valid = 1'b1;
            pick_id    = ID_W'(idx);
            pick[idx]  = 1'b1;
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter whose winner keeps the grant until done/req drop.
// Define ARB_HOLD_TIMEOUT_EN to add the MAX_HOLD watchdog and timeout pulse.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = ARB_N_REQ_DEF,
    parameter  int MAX_HOLD = ARB_MAX_HOLD_DEF,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_err
        $error("rr_lock_arbiter: N_REQ or MAX_HOLD out of range");
    end

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             release_now;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             expire;
    assign expire = (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .pick       (pick),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    // gnt_q is one-hot on the owner, so masking avoids indexing by gnt_id.
    assign release_now = |(gnt_q & (done | ~req));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
`ifdef ARB_HOLD_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_GRANT;
                    gnt_d    = pick;
                    gnt_id_d = pick_id;
                    busy_d   = 1'b1;
                    ptr_d    = ID_W'(wrap_inc(int'(pick_id), N_REQ));
`ifdef ARB_HOLD_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
                end else if (expire) begin
                    state_d   = ARB_IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
